// File: rtl/control_calculadora_pkg.sv
// Shared definitions for the keypad-driven BCD adder: FSM states, key codes,
// and key-code to digit decoding.
package calc_pkg;

  typedef enum logic [1:0] {
    CAP_N1  = 2'd0,
    CAP_N2  = 2'd1,
    SUMAR   = 2'd2,
    MOSTRAR = 2'd3
  } estado_e;

  localparam logic [3:0] TECLA_A = 4'b0011;
  localparam logic [3:0] TECLA_B = 4'b0111;
  localparam logic [3:0] TECLA_C = 4'b1011;
  localparam logic [3:0] TECLA_D = 4'b1111;

  localparam logic [1:0] SEL_N1  = 2'd0;
  localparam logic [1:0] SEL_N2  = 2'd1;
  localparam logic [1:0] SEL_RES = 2'd2;

  typedef struct packed {
    logic       valido;
    logic [3:0] valor;
  } digito_t;

  // Keypad matrix layout is not numeric; 1100 and 1110 are unused keys.
  function automatic digito_t tecla_a_digito(input logic [3:0] tecla);
    digito_t d;
    d = '{valido: 1'b1, valor: 4'd0};
    case (tecla)
      4'b0000: d.valor = 4'd1;
      4'b0001: d.valor = 4'd2;
      4'b0010: d.valor = 4'd3;
      4'b0100: d.valor = 4'd4;
      4'b0101: d.valor = 4'd5;
      4'b0110: d.valor = 4'd6;
      4'b1000: d.valor = 4'd7;
      4'b1001: d.valor = 4'd8;
      4'b1010: d.valor = 4'd9;
      4'b1101: d.valor = 4'd0;
      default: d.valido = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_calculadora_if.sv
// Keypad-in / display-out signal bundle of the calculator controller.
interface control_calculadora_if #(
  parameter int N_DIG = 3
);
  logic [3:0]               tecla_pre;
  logic                     tecla_valida;
  logic [4*(N_DIG+1)-1:0]   display_bcd;
  logic [1:0]               display_sel;
  logic                     ocupado;
  logic                     resultado_valido;

  modport master (
    output tecla_pre, tecla_valida,
    input  display_bcd, display_sel, ocupado, resultado_valido
  );

  modport slave (
    input  tecla_pre, tecla_valida,
    output display_bcd, display_sel, ocupado, resultado_valido
  );
endinterface

// File: rtl/control_calculadora_sumador_bcd_digito.sv
// Combinational single-digit BCD adder with +6 decimal correction.
module sumador_bcd_digito (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bruto;
  logic [4:0] corregido;

  always_comb begin
    bruto     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    corregido = bruto;
    cout      = 1'b0;
    if (bruto > 5'd9) begin
      corregido = bruto + 5'd6;
      cout      = 1'b1;
    end
    s = corregido[3:0];
  end

endmodule

// File: rtl/control_calculadora.sv
// Keypad calculator controller: captures two BCD operands, adds them one digit
// per cycle and shows the (N_DIG+1)-digit result.
module control_calculadora
  import calc_pkg::*;
#(
  parameter int N_DIG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             tecla_pre,
  input  logic                   tecla_valida,
  output logic [4*(N_DIG+1)-1:0] display_bcd,
  output logic [1:0]             display_sel,
  output logic                   ocupado,
  output logic                   resultado_valido
);

  localparam int OP_W  = 4 * N_DIG;
  localparam int RES_W = 4 * (N_DIG + 1);
  localparam int CNT_W = $clog2(N_DIG + 1);

  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DIG);
  localparam logic [CNT_W-1:0] IDX_FIN = CNT_W'(N_DIG - 1);

  estado_e          state_q, state_d;
  logic [OP_W-1:0]  op1_q, op1_d;
  logic [OP_W-1:0]  op2_q, op2_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic             ocupado_q, ocupado_d;
  logic             valido_q, valido_d;

  digito_t          dig;
  logic             es_c;
  logic [3:0]       sum_a, sum_b, sum_s;
  logic             sum_cout;

  assign sum_a = op1_q[4*idx_q +: 4];
  assign sum_b = op2_q[4*idx_q +: 4];

  sumador_bcd_digito u_sumador (
    .a    (sum_a),
    .b    (sum_b),
    .cin  (carry_q),
    .s    (sum_s),
    .cout (sum_cout)
  );

  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    res_d    = res_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    valido_d = 1'b0;
    dig      = tecla_a_digito(tecla_pre);
    es_c     = tecla_valida && (tecla_pre == TECLA_C);

    // Clear outranks everything, including the last addition step.
    if (es_c) begin
      state_d = CAP_N1;
      op1_d   = '0;
      op2_d   = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
      res_d   = '0;
      carry_d = 1'b0;
      idx_d   = '0;
    end else begin
      case (state_q)
        CAP_N1: begin
          if (tecla_valida) begin
            if (dig.valido) begin
              if (cnt1_q < CNT_MAX) begin
                op1_d  = (op1_q << 4) | OP_W'(dig.valor);
                cnt1_d = cnt1_q + CNT_UNO;
              end
            end else if (tecla_pre == TECLA_D) begin
              if (cnt1_q != '0) begin
                op1_d  = op1_q >> 4;
                cnt1_d = cnt1_q - CNT_UNO;
              end
            end else if (tecla_pre == TECLA_A) begin
              state_d = CAP_N2;
            end
          end
        end

        CAP_N2: begin
          if (tecla_valida) begin
            if (dig.valido) begin
              if (cnt2_q < CNT_MAX) begin
                op2_d  = (op2_q << 4) | OP_W'(dig.valor);
                cnt2_d = cnt2_q + CNT_UNO;
              end
            end else if (tecla_pre == TECLA_D) begin
              if (cnt2_q != '0) begin
                op2_d  = op2_q >> 4;
                cnt2_d = cnt2_q - CNT_UNO;
              end
            end else if (tecla_pre == TECLA_B) begin
              state_d = SUMAR;
              carry_d = 1'b0;
              idx_d   = '0;
              res_d   = '0;
            end
          end
        end

        SUMAR: begin
          res_d[4*idx_q +: 4] = sum_s;
          carry_d             = sum_cout;
          idx_d               = idx_q + CNT_UNO;
          if (idx_q == IDX_FIN) begin
            res_d[RES_W-1 -: 4] = {3'b000, sum_cout};
            idx_d               = '0;
            state_d             = MOSTRAR;
            valido_d            = 1'b1;
          end
        end

        MOSTRAR: begin
          // A new digit starts a fresh calculation with that digit as operand 1.
          if (tecla_valida && dig.valido) begin
            op1_d   = OP_W'(dig.valor);
            cnt1_d  = CNT_UNO;
            op2_d   = '0;
            cnt2_d  = '0;
            res_d   = '0;
            carry_d = 1'b0;
            state_d = CAP_N1;
          end
        end

        default: state_d = CAP_N1;
      endcase
    end

    ocupado_d = (state_d == SUMAR);
    case (state_d)
      CAP_N1:  sel_d = SEL_N1;
      MOSTRAR: sel_d = SEL_RES;
      default: sel_d = SEL_N2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CAP_N1;
      op1_q     <= '0;
      op2_q     <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sel_q     <= SEL_N1;
      ocupado_q <= 1'b0;
      valido_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      ocupado_q <= ocupado_d;
      valido_q  <= valido_d;
    end
  end

  always_comb begin
    case (state_q)
      CAP_N1:        display_bcd = RES_W'(op1_q);
      CAP_N2, SUMAR: display_bcd = RES_W'(op2_q);
      default:       display_bcd = res_q;
    endcase
  end

  assign display_sel      = sel_q;
  assign ocupado          = ocupado_q;
  assign resultado_valido = valido_q;

endmodule
